// File: rtl/transpose_collector.sv
// transpose_collector: gathers four 4-element rows into a 4x4 buffer
// (row r lands in column r) and drains the buffer as four result rows,
// so the drained matrix is the transpose of the collected one.
//
// Handshake: a result row transfers on any rising edge where
// OutValid && OutReady. While OutValid is high and OutReady is low,
// OutRow*, OutIndex and OutValid hold stable. Input rows are accepted
// on any rising edge where InReady && InValid; InValid outside COLLECT
// is a protocol error.
//
// DbgState exposes the FSM state: 0=IDLE, 1=COLLECT, 2=DRAIN, 3=FINISH.
module transpose_collector #(
    parameter int DW = 32
) (
    input  logic          Clock,
    input  logic          ClearAll_n,
    input  logic          Start,
    input  logic          InValid,
    input  logic [DW-1:0] InRow1,
    input  logic [DW-1:0] InRow2,
    input  logic [DW-1:0] InRow3,
    input  logic [DW-1:0] InRow4,
    output logic          InReady,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] OutRow1,
    output logic [DW-1:0] OutRow2,
    output logic [DW-1:0] OutRow3,
    output logic [DW-1:0] OutRow4,
    output logic [1:0]    OutIndex,
    output logic          OutLast,
    output logic          Busy,
    output logic          Done,
    output logic          Error,
    output logic [1:0]    DbgState
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    row_cnt;
    logic [1:0]    out_cnt;
    logic          err_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] mat_q [4][4];

    // FSM: state, counters, sticky error and registered status flags
    always_ff @(posedge Clock or negedge ClearAll_n) begin
        if (!ClearAll_n) begin
            state       <= S_IDLE;
            row_cnt     <= 2'd0;
            out_cnt     <= 2'd0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Start wins over a simultaneous InValid; that row is dropped
                    if (Start) begin
                        state      <= S_COLLECT;
                        row_cnt    <= 2'd0;
                        out_cnt    <= 2'd0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (InValid) begin
                        err_q <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (Start) begin
                        err_q <= 1'b1;
                    end
                    if (InValid) begin
                        row_cnt <= row_cnt + 2'd1;
                        if (row_cnt == 2'd3) begin
                            state       <= S_DRAIN;
                            out_cnt     <= 2'd0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (Start || InValid) begin
                        err_q <= 1'b1;
                    end
                    if (OutReady) begin
                        out_cnt <= out_cnt + 2'd1;
                        if (out_cnt == 2'd3) begin
                            state       <= S_FINISH;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: begin
                    // FINISH lasts one cycle, carrying the Done pulse
                    if (Start || InValid) begin
                        err_q <= 1'b1;
                    end
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Buffer: incoming row r is written into column r
    always_ff @(posedge Clock or negedge ClearAll_n) begin
        if (!ClearAll_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    mat_q[i][j] <= '0;
                end
            end
        end else if (state == S_COLLECT && InValid) begin
            mat_q[0][row_cnt] <= InRow1;
            mat_q[1][row_cnt] <= InRow2;
            mat_q[2][row_cnt] <= InRow3;
            mat_q[3][row_cnt] <= InRow4;
        end
    end

    // Result row k is buffer row k, i.e. column k of the collected input
    assign OutRow1  = out_valid_q ? mat_q[out_cnt][0] : '0;
    assign OutRow2  = out_valid_q ? mat_q[out_cnt][1] : '0;
    assign OutRow3  = out_valid_q ? mat_q[out_cnt][2] : '0;
    assign OutRow4  = out_valid_q ? mat_q[out_cnt][3] : '0;
    assign OutIndex = out_cnt;
    assign OutLast  = out_valid_q && (out_cnt == 2'd3);
    assign OutValid = out_valid_q;
    assign InReady  = in_ready_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Error    = err_q;
    assign DbgState = state;

endmodule
